// File: rtl/or1200_if_buf.sv
// ----------------------------------------------------------------------------
// or1200_if_buf
//
// Instruction-fetch stage with a DEPTH-entry instruction buffer placed between
// the IC CPU port and decode. Responses that arrive while the pipeline is
// frozen are queued (insn, pc, error flags) and drained in order, one per
// unfrozen cycle. A response arriving to an empty, unfrozen buffer goes
// straight to decode in the same cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   icpu_dat_i        instruction word from the IC
//   icpu_ack_i        response valid, no error
//   icpu_err_i        response valid, with error (tag in icpu_tag_i)
//   icpu_adr_i        response address; bit 0 marks a discarded fetch
//   icpu_tag_i        error tag (d = TLB miss, c = page fault, b = bus error)
//   if_freeze         head is held, not consumed
//   if_flushpipe      empties the buffer at the next edge
//   no_more_dslot     forces NOP and masks exceptions
//   rfe               forces NOP
//   if_insn, if_pc    instruction/address presented to decode
//   if_stall          nothing to present
//   genpc_refetch     a response was dropped on a full buffer
//   if_full, if_count occupancy status
//   except_*          exception flags for the presented instruction
// ----------------------------------------------------------------------------
module or1200_if_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   icpu_dat_i,
    input  logic          icpu_ack_i,
    input  logic          icpu_err_i,
    input  logic [31:0]   icpu_adr_i,
    input  logic [3:0]    icpu_tag_i,
    input  logic          if_freeze,
    input  logic          if_flushpipe,
    input  logic          no_more_dslot,
    input  logic          rfe,
    output logic [31:0]   if_insn,
    output logic [31:0]   if_pc,
    output logic          if_stall,
    output logic          genpc_refetch,
    output logic          if_full,
    output logic [AW:0]   if_count,
    output logic          except_itlbmiss,
    output logic          except_immufault,
    output logic          except_ibuserr
);

    localparam logic [31:0] NOP_INSN  = 32'h1441_0000;
    localparam logic [31:0] IDLE_INSN = 32'h1461_0000;
    localparam logic [3:0]  TAG_TE    = 4'hd;
    localparam logic [3:0]  TAG_PE    = 4'hc;
    localparam logic [3:0]  TAG_BE    = 4'hb;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [29:0] pc;
        logic [2:0]  err;   // {BE, PE, TE}
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic            bypass_reg;

    logic            in_v, empty, full, out_v;
    logic            pop, pop_buf, push, do_push;
    logic            bypass;
    logic [2:0]      in_err;
    entry_t          in_entry;
    entry_t          head_e;

    // Bit 1 of the response address carries no information for a
    // word-aligned instruction stream.
    logic            unused_adr_bit;
    assign unused_adr_bit = icpu_adr_i[1];

    assign in_v    = icpu_ack_i | icpu_err_i;
    assign empty   = (count == '0);
    assign full    = (count == CNT_DEPTH);
    assign out_v   = !empty | in_v;
    assign pop     = out_v & !if_freeze & !if_flushpipe;
    // With an empty buffer the pop is served by the bypass path, not memory.
    assign pop_buf = pop & !empty;
    assign push    = in_v & !if_flushpipe & !(empty & !if_freeze);
    // A full buffer still accepts when the head leaves in the same cycle.
    assign do_push = push & (!full | pop_buf);

    assign in_err = {3{icpu_err_i}} & {icpu_tag_i == TAG_BE,
                                       icpu_tag_i == TAG_PE,
                                       icpu_tag_i == TAG_TE};

    assign in_entry.insn = icpu_err_i ? NOP_INSN : icpu_dat_i;
    assign in_entry.pc   = icpu_adr_i[31:2];
    assign in_entry.err  = in_err;

    assign head_e = mem[head];

    // After a flush every response is squashed to NOP until the fetch unit
    // signals (adr bit 0) that the discarded stream has ended.
    assign bypass = icpu_adr_i[0] ? 1'b0 : (bypass_reg | if_flushpipe);

    // Pointer / occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            bypass_reg <= 1'b0;
        end else begin
            bypass_reg <= bypass;
            if (if_flushpipe) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop_buf) head <= head + PTR_ONE;
                if (do_push) tail <= tail + PTR_ONE;
                case ({do_push, pop_buf})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !if_flushpipe) mem[tail] <= in_entry;
    end

    always_comb begin
        if_insn = IDLE_INSN;
        if (no_more_dslot | rfe | bypass) if_insn = NOP_INSN;
        else if (!empty)                  if_insn = head_e.insn;
        else if (icpu_ack_i)              if_insn = icpu_dat_i;
    end

    always_comb begin
        {except_ibuserr, except_immufault, except_itlbmiss} = 3'b000;
        if (!no_more_dslot) begin
            if (!empty)
                {except_ibuserr, except_immufault, except_itlbmiss} = head_e.err;
            else
                {except_ibuserr, except_immufault, except_itlbmiss} = in_err;
        end
    end

    assign if_pc         = !empty ? {head_e.pc, 2'b00} : {icpu_adr_i[31:2], 2'b00};
    assign if_stall      = !out_v;
    assign genpc_refetch = push & full & !pop_buf;
    assign if_full       = full;
    assign if_count      = count;

endmodule

// File: tb/tb_or1200_if_buf.sv
// ----------------------------------------------------------------------------
// tb_or1200_if_buf
//
// Scoreboard bench for or1200_if_buf. A driver applies one stimulus vector per
// cycle, asks a queue-based reference model for the expected outputs and
// pushes them to a scoreboard; a separate monitor pops and compares at the
// falling edge. Directed scenarios come first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_or1200_if_buf;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam logic [31:0] NOP_I  = 32'h1441_0000;
    localparam logic [31:0] IDLE_I = 32'h1461_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   icpu_dat_i = '0;
    logic          icpu_ack_i = 1'b0;
    logic          icpu_err_i = 1'b0;
    logic [31:0]   icpu_adr_i = '0;
    logic [3:0]    icpu_tag_i = '0;
    logic          if_freeze = 1'b0;
    logic          if_flushpipe = 1'b0;
    logic          no_more_dslot = 1'b0;
    logic          rfe = 1'b0;
    logic [31:0]   if_insn, if_pc;
    logic          if_stall, genpc_refetch, if_full;
    logic [AW:0]   if_count;
    logic          except_itlbmiss, except_immufault, except_ibuserr;

    or1200_if_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .icpu_dat_i(icpu_dat_i), .icpu_ack_i(icpu_ack_i), .icpu_err_i(icpu_err_i),
        .icpu_adr_i(icpu_adr_i), .icpu_tag_i(icpu_tag_i),
        .if_freeze(if_freeze), .if_flushpipe(if_flushpipe),
        .no_more_dslot(no_more_dslot), .rfe(rfe),
        .if_insn(if_insn), .if_pc(if_pc), .if_stall(if_stall),
        .genpc_refetch(genpc_refetch), .if_full(if_full), .if_count(if_count),
        .except_itlbmiss(except_itlbmiss), .except_immufault(except_immufault),
        .except_ibuserr(except_ibuserr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [2:0]  err;   // {BE, PE, TE}
    } ent_t;

    typedef struct {
        int          cnt;
        bit          full, stall, refetch;
        logic [31:0] insn, pc;
        logic [2:0]  exc;   // {ibuserr, immufault, itlbmiss}
    } exp_t;

    ent_t q[$];       // reference buffer contents, head at index 0
    bit   bpreg;      // reference "squash until discarded fetch" flag
    exp_t exp_q[$];   // scoreboard
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] tag_flags(input logic e, input logic [3:0] t);
        return e ? {t == 4'hb, t == 4'hc, t == 4'hd} : 3'b000;
    endfunction

    // One cycle: drive inputs, predict outputs, advance the model past the edge.
    task automatic cyc(input logic [31:0] d, input logic a, input logic e,
                       input logic [31:0] ad, input logic [3:0] t,
                       input logic fz, input logic fl, input logic nm,
                       input logic rf, input logic r);
        exp_t x;
        ent_t n;
        bit   emp, inv, bp, would_push;
        rst = r; icpu_dat_i = d; icpu_ack_i = a; icpu_err_i = e;
        icpu_adr_i = ad; icpu_tag_i = t; if_freeze = fz; if_flushpipe = fl;
        no_more_dslot = nm; rfe = rf;
        if (r) begin q.delete(); bpreg = 0; end
        emp = (q.size() == 0);
        inv = a | e;
        bp  = ad[0] ? 1'b0 : (bpreg | fl);
        would_push = inv && !fl && !(emp && !fz);
        x.cnt     = q.size();
        x.full    = (q.size() == DEPTH);
        x.stall   = emp && !inv;
        // Only a frozen full buffer can refuse: otherwise the head leaves.
        x.refetch = would_push && fz && (q.size() == DEPTH);
        if (nm || rf || bp) x.insn = NOP_I;
        else if (!emp)      x.insn = q[0].insn;
        else if (a)         x.insn = d;
        else                x.insn = IDLE_I;
        x.pc  = emp ? {ad[31:2], 2'b00} : q[0].pc;
        x.exc = nm ? 3'b000 : (!emp ? q[0].err : tag_flags(e, t));
        exp_q.push_back(x);

        @(posedge clk);
        if (r) begin
            q.delete(); bpreg = 0;
        end else begin
            bpreg = bp;
            if (fl) q.delete();
            else begin
                if (!fz && !emp) void'(q.pop_front());
                if (would_push && q.size() < DEPTH) begin
                    n.insn = e ? NOP_I : d;
                    n.pc   = {ad[31:2], 2'b00};
                    n.err  = tag_flags(e, t);
                    q.push_back(n);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic fz);
        cyc(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, fz, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack(input logic [31:0] d, input logic [31:0] ad, input logic fz);
        cyc(d, 1'b1, 1'b0, ad, 4'h0, fz, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("count",   32'(if_count),      32'(x.cnt));
                chk("full",    32'(if_full),       32'(x.full));
                chk("stall",   32'(if_stall),      32'(x.stall));
                chk("refetch", 32'(genpc_refetch), 32'(x.refetch));
                chk("insn",    if_insn,            x.insn);
                chk("exc",     32'({except_ibuserr, except_immufault, except_itlbmiss}),
                               32'(x.exc));
                if (!x.stall) chk("pc", if_pc, x.pc);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        // Reset with idle IC inputs
        cyc(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Zero-latency bypass
        ack(32'hA5A5_0001, 32'h100, 1'b0);
        idle(1'b0);

        // Queue three while frozen, then drain
        ack(32'h1111_0000, 32'h200, 1'b1);
        ack(32'h2222_0000, 32'h204, 1'b1);
        ack(32'h3333_0000, 32'h208, 1'b1);
        repeat (4) idle(1'b0);

        // Overfill: DEPTH+1 responses while frozen, then drain
        for (int i = 0; i <= DEPTH; i++) ack(32'hC0DE_0000 + i, 32'h400 + 4 * i, 1'b1);
        idle(1'b1);
        repeat (DEPTH + 1) idle(1'b0);

        // Page-fault response, then the same with no_more_dslot
        cyc(32'hDEAD_BEEF, 1'b0, 1'b1, 32'h500, 4'hc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(32'hDEAD_BEEF, 1'b0, 1'b1, 32'h504, 4'hc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Flush (together with freeze) on a two-entry buffer
        ack(32'h7777_0000, 32'h600, 1'b1);
        ack(32'h7777_0004, 32'h604, 1'b1);
        cyc(32'h7777_0008, 1'b1, 1'b0, 32'h608, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        ack(32'h8888_0000, 32'h700, 1'b0);         // still squashed
        ack(32'h8888_0004, 32'h705, 1'b0);         // discarded-fetch marker
        ack(32'h8888_0008, 32'h708, 1'b0);         // stream live again

        // Reset in the middle of a drain
        ack(32'h9999_0000, 32'h800, 1'b1);
        ack(32'h9999_0004, 32'h804, 1'b1);
        ack(32'h9999_0008, 32'h808, 1'b1);
        idle(1'b0);
        cyc(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ack(32'hAAAA_0000, 32'h900, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] tags [4];
            logic a, e;
            tags[0] = 4'hb; tags[1] = 4'hc; tags[2] = 4'hd; tags[3] = 4'(($urandom));
            a = ($urandom % 3) == 0;
            e = !a && (($urandom % 6) == 0);
            cyc($urandom, a, e,
                {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, ($urandom % 8) == 0},
                tags[$urandom % 4],
                ($urandom % 3) != 0, ($urandom % 30) == 0,
                ($urandom % 20) == 0, ($urandom % 20) == 0,
                ($urandom % 400) == 0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
